slice_sequencer: RTL



---
 rtl/slice_sequencer_if.sv | 37 +++
 rtl/slice_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/slice_sequencer_if.sv
// ============================================================================
// Module      : slice_sequencer_if
// Description : Producer/consumer handshake bundle for slice_sequencer.
//               The slave modport is the sequencer; the master modport is the
//               producer/consumer environment around it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slice_sequencer_if #(
   parameter int INPUT_DATA_WIDTH = 32,
   parameter int FIELD_WIDTH      = 8,
   parameter int NUM_FIELDS       = 4
);
   localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

   logic [INPUT_DATA_WIDTH-1:0] data_in;
   logic                        data_in_valid;
   logic                        data_in_ready;
   logic [FIELD_WIDTH-1:0]      data_out;
   logic                        data_out_valid;
   logic                        data_out_ready;
   logic [IDX_W-1:0]            field_index;
   logic                        last;

   modport slave (
      input  data_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, data_out_valid, field_index, last
   );

   modport master (
      output data_in, data_in_valid, data_out_ready,
      input  data_in_ready, data_out, data_out_valid, field_index, last
   );
endinterface

`default_nettype wire

// File: rtl/slice_sequencer.sv
// ============================================================================
// Module      : slice_sequencer
// Description : Splits each wide input word into NUM_FIELDS fixed-width fields
//               and emits them one per cycle with valid/ready on both sides.
//               Consecutive words stream with no idle cycle between them.
//               Optional feature macro: SLICE_SEQUENCER_STATS_EN adds a 16-bit
//               word_count output counting completed words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_sequencer #(
   parameter int INPUT_DATA_WIDTH  = 32,
   parameter int FIELD_WIDTH       = 8,
   parameter int NUM_FIELDS        = 4,
   parameter bit OFFSET_REL_TO_MSB = 1'b1
) (
   input  wire logic        clk,
   input  wire logic        rst,
`ifdef SLICE_SEQUENCER_STATS_EN
   output      logic [15:0] word_count,
`endif
   slice_sequencer_if.slave bus
);

   localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

   // Reject configurations where the fields do not fit in the input word.
   generate
      if (NUM_FIELDS < 1 || NUM_FIELDS * FIELD_WIDTH > INPUT_DATA_WIDTH) begin : g_bad_params
         $error("slice_sequencer: NUM_FIELDS*FIELD_WIDTH must be <= INPUT_DATA_WIDTH");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [INPUT_DATA_WIDTH-1:0] hold_q, hold_d;

   logic                        w_busy;
   logic                        w_last;
   logic                        w_in_ready;
   logic                        w_in_xfer;
   logic                        w_out_xfer;
   logic [FIELD_WIDTH-1:0]      w_fields [NUM_FIELDS];
   logic [FIELD_WIDTH-1:0]      w_field;
   logic                        w_unused_hold;

   assign w_busy     = (state_q == ST_BUSY);
   assign w_last     = w_busy & (idx_q == LAST_IDX);
   // Accepting while the last field leaves is what makes back-to-back words bubble-free.
   assign w_in_ready = ~w_busy | (w_last & bus.data_out_ready);
   assign w_in_xfer  = bus.data_in_valid & w_in_ready;
   assign w_out_xfer = w_busy & bus.data_out_ready;

   // Fixed slice offsets of the hold register, one per field.
   generate
      for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
         if (OFFSET_REL_TO_MSB) begin : g_msb
            assign w_fields[g] = hold_q[INPUT_DATA_WIDTH-1-g*FIELD_WIDTH -: FIELD_WIDTH];
         end else begin : g_lsb
            assign w_fields[g] = hold_q[g*FIELD_WIDTH +: FIELD_WIDTH];
         end
      end
   endgenerate

   // Bits outside every field are intentionally dropped.
   assign w_unused_hold = ^hold_q;

   // Select the field addressed by the index register.
   always_comb begin
      w_field = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_field = w_fields[i];
         end
      end
   end

   // Next-state: load on input transfer, advance or retire on output transfer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      if (w_in_xfer) begin
         hold_d  = bus.data_in;
         idx_d   = '0;
         state_d = ST_BUSY;
      end else if (w_out_xfer) begin
         if (w_last) begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
         end
      end
   end

   // State, index and hold registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.data_in_ready  = w_in_ready;
   assign bus.data_out       = w_field;
   assign bus.data_out_valid = w_busy;
   assign bus.field_index    = idx_q;
   assign bus.last           = w_last;

`ifdef SLICE_SEQUENCER_STATS_EN
   logic [15:0] count_q, count_d;

   // Count words whose final field has been handed to the consumer; wraps at 16 bits.
   always_comb begin
      count_d = count_q;
      if (w_out_xfer & w_last) begin
         count_d = count_q + 16'd1;
      end
   end

   // Completed-word counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign word_count = count_q;
`endif

endmodule

`default_nettype wire
